kronos_dmem_ctrl: RTL

KRONOS_DMEM_CTRL -- requirements
Module: kronos_dmem_ctrl

---
 rtl/kronos_types.sv | 18 +
 rtl/kronos_dmem_wbuf.sv | 35 +++
 rtl/kronos_dmem_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/kronos_types.sv
// Shared types for the Kronos data-memory controller: FSM state encoding
// and the registered request payload.
package kronos_types;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        wr_en;
    } dmem_req_t;

endpackage

// File: rtl/kronos_dmem_wbuf.sv
// One-entry posted write buffer for the Kronos data-memory controller.
// Only instantiated when KRONOS_DMEM_WBUF_EN is defined.
module kronos_dmem_wbuf #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    mask,
    output logic          valid,
    output logic [AW-1:0] entry_addr,
    output logic [31:0]   entry_wdata,
    output logic [3:0]    entry_mask
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= 1'b0;
            entry_addr  <= '0;
            entry_wdata <= '0;
            entry_mask  <= '0;
        end else if (load) begin
            valid       <= 1'b1;
            entry_addr  <= addr;
            entry_wdata <= wdata;
            entry_mask  <= mask;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/kronos_dmem_ctrl.sv
// Kronos data-memory controller: IDLE/ACCESS/RESP handshake onto a single-port
// SRAM. Define KRONOS_DMEM_WBUF_EN to add a one-entry posted write buffer.
module kronos_dmem_ctrl
    import kronos_types::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_wr_data,
    input  logic [3:0]    data_wr_mask,
    input  logic          data_wr_en,
    input  logic          data_req,
    output logic [31:0]   data_rd_data,
    output logic          data_ack,
    output logic          data_err,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic [3:0]    sram_wr_mask,
    output logic          sram_wr_en,
    output logic          sram_en,
    input  logic [31:0]   sram_rdata
);

    state_t    state, state_nxt;
    dmem_req_t req_q;
    logic      oor_q;
    logic      accept;
    logic      req_oor;
    logic      unused_addr_bits;

    assign req_oor          = |data_addr[31:AW+2];
    assign unused_addr_bits = ^{req_q.addr[31:AW+2], req_q.addr[1:0], data_addr[1:0]};

`ifdef KRONOS_DMEM_WBUF_EN
    logic          wbuf_load;
    logic          wbuf_drain;
    logic          wbuf_valid;
    logic [AW-1:0] wbuf_addr;
    logic [31:0]   wbuf_wdata;
    logic [3:0]    wbuf_mask;

    kronos_dmem_wbuf #(
        .AW(AW)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .load        (wbuf_load),
        .drain       (wbuf_drain),
        .addr        (data_addr[AW+1:2]),
        .wdata       (data_wr_data),
        .mask        (data_wr_mask),
        .valid       (wbuf_valid),
        .entry_addr  (wbuf_addr),
        .entry_wdata (wbuf_wdata),
        .entry_mask  (wbuf_mask)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req_q <= '0;
            oor_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q.addr  <= data_addr;
                req_q.wdata <= data_wr_data;
                req_q.mask  <= data_wr_mask;
                req_q.wr_en <= data_wr_en;
                oor_q       <= req_oor;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        sram_en      = 1'b0;
        sram_wr_en   = 1'b0;
        sram_addr    = req_q.addr[AW+1:2];
        sram_wdata   = req_q.wdata;
        sram_wr_mask = req_q.mask;
        data_ack     = 1'b0;
        data_err     = 1'b0;
        data_rd_data = '0;
`ifdef KRONOS_DMEM_WBUF_EN
        wbuf_load    = 1'b0;
        wbuf_drain   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
`ifdef KRONOS_DMEM_WBUF_EN
                // A pending posted store owns the SRAM this cycle; any request
                // waits one cycle so a following load sees the drained data.
                if (wbuf_valid) begin
                    wbuf_drain   = 1'b1;
                    sram_en      = 1'b1;
                    sram_wr_en   = 1'b1;
                    sram_addr    = wbuf_addr;
                    sram_wdata   = wbuf_wdata;
                    sram_wr_mask = wbuf_mask;
                end else if (data_req) begin
                    accept = 1'b1;
                    if (data_wr_en && !req_oor) begin
                        wbuf_load = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
`else
                if (data_req) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
`endif
            end
            ACCESS: begin
                sram_en    = !oor_q;
                sram_wr_en = !oor_q && req_q.wr_en;
                state_nxt  = RESP;
            end
            RESP: begin
                data_ack     = 1'b1;
                data_err     = oor_q;
                data_rd_data = (oor_q || req_q.wr_en) ? 32'h0 : sram_rdata;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
